// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected neuron.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fc_state_e;

  // Accumulator width: full-precision products, growth over IN terms, one guard bit for bias.
  function automatic int acc_width(input int width, input int in);
    return 2 * width + $clog2(in) + 1;
  endfunction

endpackage

// File: rtl/fc_lane_sum.sv
// Registered signed adder tree that reduces the LANES products of one beat to a single sum.
module fc_lane_sum
  import fc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   vld_p1,
  input  logic [LANES*2*WIDTH-1:0]               prod_p1,
  output logic                                   vld_p2,
  output logic signed [2*WIDTH+$clog2(LANES)-1:0] sum_p2
);

  localparam int PW    = 2 * WIDTH;
  localparam int SUM_W = PW + $clog2(LANES);
  localparam int NODES = 2 * LANES;

  function automatic logic signed [SUM_W-1:0] add2(input logic signed [SUM_W-1:0] a,
                                                   input logic signed [SUM_W-1:0] b);
    return a + b;
  endfunction

  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_p2_q;
  logic                    vld_p2_q;

  // Heap-ordered tree: leaves at LANES..2*LANES-1, node i sums children 2i and 2i+1.
  always_comb begin : tree
    logic signed [SUM_W-1:0] node [NODES];
    node[0] = '0;
    for (int k = 0; k < LANES; k++) begin
      node[LANES+k] = SUM_W'($signed(prod_p1[k*PW +: PW]));
    end
    for (int i = LANES - 1; i >= 1; i--) begin
      node[i] = add2(node[2*i], node[2*i+1]);
    end
    sum_d = node[1];
  end

  // P2 boundary: valid flag is control and is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2_q <= 1'b0;
    else        vld_p2_q <= vld_p1;
  end

  // P2 boundary: lane sum data, captured only when a beat is in flight.
  always_ff @(posedge clk) begin
    if (vld_p1) sum_p2_q <= sum_d;
  end

  assign vld_p2 = vld_p2_q;
  assign sum_p2 = sum_p2_q;

endmodule

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed FC neuron: LANES multiplies per beat, lane-sum tree, bias-preloaded
// accumulator, optional ReLU, valid/ready result port.
module fc_neuron_seq
  import fc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int IN      = 128,
  parameter int LANES   = 4,
  parameter int RELU_EN = 1,
  parameter int ACC_W   = acc_width(WIDTH, IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_we,
  input  logic [$clog2(IN+1)-1:0]  w_addr,
  input  logic signed [WIDTH-1:0]  w_data,
  output logic                     busy,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [LANES*WIDTH-1:0]   s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [ACC_W-1:0]  m_data
);

  localparam int NBEATS = IN / LANES;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int AW     = $clog2(IN + 1);
  localparam int IDX_W  = (IN > 1) ? $clog2(IN) : 1;
  localparam int PW     = 2 * WIDTH;
  localparam int SUM_W  = PW + $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  if (IN % LANES != 0) begin : g_bad_cfg
    $error("fc_neuron_seq: IN must be a multiple of LANES");
  end

  function automatic logic signed [ACC_W-1:0] relu_fn(input logic signed [ACC_W-1:0] v);
    if (RELU_EN != 0 && v[ACC_W-1]) return '0;
    return v;
  endfunction

  // Control state
  fc_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    drain_q, drain_d;
  logic                    s_ready_q, s_ready_d;
  logic                    busy_q, busy_d;
  logic                    m_valid_q, m_valid_d;
  logic signed [ACC_W-1:0] m_data_q, m_data_d;

  // Datapath
  logic signed [WIDTH-1:0] w_mem_q [IN];
  logic signed [ACC_W-1:0] bias_q, bias_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LANES*PW-1:0]     prod_d, prod_p1_q;
  logic                    vld_p1_q, first_p1_q, first_p2_q;
  logic                    vld_p2;
  logic signed [SUM_W-1:0] sum_p2;

  logic beat_acc, last_beat, wr_ok, mem_we;

  assign beat_acc  = s_valid && s_ready_q;
  assign last_beat = beat_acc && (cnt_q == LAST_BEAT);
  // A beat in the same cycle wins over a write; writes are only taken while idle.
  assign wr_ok     = w_we && !busy_q && !beat_acc;
  assign mem_we    = wr_ok && (w_addr < AW'(IN));

  // Bias register update: w_addr == IN selects it, value sign-extended.
  always_comb begin
    bias_d = bias_q;
    if (wr_ok && (w_addr == AW'(IN))) bias_d = ACC_W'(w_data);
  end

  // Weight store: plain register array, deliberately not reset so weights survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) w_mem_q[w_addr[IDX_W-1:0]] <= w_data;
  end

  // Lane products for the current beat, weights selected at cnt*LANES + k.
  always_comb begin : mult
    logic [IDX_W-1:0]        idx;
    logic signed [WIDTH-1:0] a;
    prod_d = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = IDX_W'(int'(cnt_q) * LANES + k);
      a   = $signed(s_data[k*WIDTH +: WIDTH]);
      prod_d[k*PW +: PW] = PW'(a) * PW'(w_mem_q[idx]);
    end
  end

  // P1 boundary: products, captured only on an accepted beat.
  always_ff @(posedge clk) begin
    if (beat_acc) prod_p1_q <= prod_d;
  end

  // P1/P2 boundary control: valid and first-beat marker travel with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      first_p2_q <= 1'b0;
    end else begin
      vld_p1_q   <= beat_acc;
      first_p1_q <= beat_acc && (cnt_q == '0);
      first_p2_q <= first_p1_q;
    end
  end

  fc_lane_sum #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_sum (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_p1  (vld_p1_q),
    .prod_p1 (prod_p1_q),
    .vld_p2  (vld_p2),
    .sum_p2  (sum_p2)
  );

  // P3 accumulate: first beat of a vector restarts from the bias instead of the old sum.
  always_comb begin
    acc_d = acc_q;
    if (vld_p2) acc_d = (first_p2_q ? bias_q : acc_q) + ACC_W'(sum_p2);
  end

  // P3 boundary: accumulator and bias, both cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      bias_q <= '0;
    end else begin
      acc_q  <= acc_d;
      bias_q <= bias_d;
    end
  end

  // FSM next state; the result is latched from acc_d so it appears together with m_valid.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    m_data_d = m_data_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat_acc) begin
          cnt_d   = last_beat ? '0 : cnt_q + CNT_W'(1);
          state_d = last_beat ? DRAIN : ACCUM;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d  = OUT;
          m_data_d = relu_fn(acc_d);
        end else begin
          drain_d = 1'b1;
        end
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    busy_d    = (state_d != IDLE);
    m_valid_d = (state_d == OUT);
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Bench for fc_neuron_seq: two instances (ReLU on / off) share stimulus; results are
// compared against a plain-arithmetic dot-product model.
module tb_fc_neuron_seq;

  localparam int WIDTH = 8;
  localparam int IN    = 128;
  localparam int LANES = 4;
  localparam int NB    = IN / LANES;
  localparam int ACC_W = 2 * WIDTH + $clog2(IN) + 1;
  localparam int AW    = $clog2(IN + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   w_we;
  logic [AW-1:0]          w_addr;
  logic [WIDTH-1:0]       w_data;
  logic                   s_valid;
  logic [LANES*WIDTH-1:0] s_data;
  logic                   m_ready;

  logic             busy1, s_ready1, m_valid1;
  logic [ACC_W-1:0] m_data1;
  logic             busy0, s_ready0, m_valid0;
  logic [ACC_W-1:0] m_data0;

  int wm [IN];
  int xv [IN];
  int bm;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy1), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1)
  );

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(0)) u_lin (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy0), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input int relu);
    longint s;
    s = longint'(bm);
    for (int i = 0; i < IN; i++) s += longint'(xv[i]) * longint'(wm[i]);
    if (relu != 0 && s < 0) s = 0;
    return s;
  endfunction

  function automatic longint sx(input logic [ACC_W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic drive_beat(input int b);
    for (int k = 0; k < LANES; k++) s_data[k*WIDTH +: WIDTH] = WIDTH'(xv[b*LANES+k]);
  endtask

  task automatic wr(input int addr, input int data);
    @(posedge clk); #1;
    w_we = 1'b1; w_addr = AW'(addr); w_data = WIDTH'(data);
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  // mode 0: all 1, 1: all -1, 2: all -128, 3: random
  task automatic load_weights(input int mode);
    for (int i = 0; i < IN; i++) begin
      int v;
      case (mode)
        0:       v = 1;
        1:       v = -1;
        2:       v = -128;
        default: v = int'($urandom_range(0, 255)) - 128;
      endcase
      @(posedge clk); #1;
      w_we = 1'b1; w_addr = AW'(i); w_data = WIDTH'(v);
      wm[i] = v;
    end
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic fill_x(input int rnd, input int val);
    for (int i = 0; i < IN; i++) xv[i] = (rnd != 0) ? int'($urandom_range(0, 255)) - 128 : val;
  endtask

  task automatic run_vector(input string name, input int gaps, input int hold, input int wr_busy);
    int     beat;
    int     cyc;
    longint e1, e0;
    e1 = model(1);
    e0 = model(0);
    beat = 0;
    cyc = 0;
    while (beat < NB && cyc < 2000) begin
      @(posedge clk); #1;
      s_valid = (gaps != 0 && beat != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive_beat(beat);
      w_we   = (wr_busy != 0) && (beat == 0 || beat == 5);
      w_addr = '0;
      w_data = 8'd7;
      @(negedge clk);
      if (s_valid && s_ready1) beat++;
      cyc++;
    end
    if (beat < NB) check({name, "_beat_timeout"}, beat, NB);
    // cycle T+1
    @(posedge clk); #1;
    s_valid = 1'b0; w_we = 1'b0;
    @(negedge clk);
    check({name, "_lat1_vld"}, m_valid1, 0);
    check({name, "_busy"}, busy1, 1);
    // cycle T+2
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_lat2_vld"}, m_valid1, 0);
    // cycle T+3
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_vld_relu"}, m_valid1, 1);
    check({name, "_vld_lin"}, m_valid0, 1);
    check({name, "_data_relu"}, sx(m_data1), e1);
    check({name, "_data_lin"}, sx(m_data0), e0);
    check({name, "_srdy"}, s_ready1, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      w_we = (wr_busy != 0); w_addr = '0; w_data = 8'd7;
      @(negedge clk);
      check({name, "_hold_vld"}, m_valid1, 1);
      check({name, "_hold_data"}, sx(m_data1), e1);
      check({name, "_hold_srdy"}, s_ready0, 0);
    end
    @(posedge clk); #1;
    w_we = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check({name, "_hs_vld"}, m_valid1, 1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check({name, "_post_srdy"}, s_ready1, 1);
    check({name, "_post_vld"}, m_valid1, 0);
    check({name, "_post_busy"}, busy1, 0);
  endtask

  task automatic reset_mid(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      drive_beat(b);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_srdy", s_ready1, 1);
    check("midrst_vld", m_valid1, 0);
    check("midrst_data", sx(m_data1), 0);
    check("midrst_busy", busy1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bm = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst_no_output", m_valid0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_n = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; bm = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_srdy", s_ready1, 1);
    check("rst_srdy_lin", s_ready0, 1);
    check("rst_vld", m_valid1, 0);
    check("rst_data", sx(m_data1), 0);
    check("rst_busy", busy1, 0);
    check("rst_busy_lin", busy0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all ones
    load_weights(0);
    wr(IN, 0); bm = 0;
    fill_x(0, 1);
    run_vector("ones", 0, 0, 0);

    // negative result, ReLU vs linear
    load_weights(1);
    fill_x(0, 5);
    run_vector("neg", 0, 2, 0);

    // extremes
    load_weights(2);
    wr(IN, 127); bm = 127;
    fill_x(0, -128);
    run_vector("extreme", 0, 0, 0);

    // out-of-range address must not alias onto a weight
    wr(IN + 1, 99);
    fill_x(1, 0);
    run_vector("oob_addr", 0, 0, 0);

    // random weights, bias, activations, input gaps and output stalls
    load_weights(3);
    bm = int'($urandom_range(0, 255)) - 128;
    wr(IN, bm);
    for (int it = 0; it < 3; it++) begin
      fill_x(1, 0);
      run_vector("rand", 1, (it == 0) ? 10 : it, 0);
    end

    // writes while busy (and on the first beat) are dropped
    fill_x(1, 0);
    run_vector("wr_busy", 1, 3, 1);
    fill_x(1, 0);
    run_vector("after_wr_busy", 0, 0, 0);

    // reset in the middle of a vector
    fill_x(1, 0);
    reset_mid(10);
    fill_x(1, 0);
    run_vector("after_rst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
